pipe_stage_ctrl: RTL and testbench

Pipeline sequencing block that consumes the hazard unit's stall, flush and kill requests and turns them into per-stage valid state. It owns the fetch PC, the per-stage PC copies, and the global advance strobe. Redirects that arrive while the memories are busy are held until they can be applied. It sits between the hazard detection unit and the five pipeline registers (IF/ID/EX/MEM/WB) and drives the `*_invalid`, `*_PC` and `go_to_next` signals back into it.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stage_reg.sv | 46 ++++
 rtl/pipe_stage_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline sequencing block.
// Stage indices, PC width and the sequential fetch step.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int NSTAGE = 5;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef logic [XLEN-1:0] pc_t;

  // Sequential fetch; wraps silently at 2^XLEN.
  function automatic pc_t pc_inc(input pc_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit plus PC with advance/hold/kill controls.
// A held stage keeps its PC but can still be killed in place.
module pipe_stage_reg
  import pipe_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic adv_i,
  input  logic hold_i,
  input  logic kill_i,
  input  logic v_i,
  input  pc_t  pc_i,
  output logic v_o,
  output pc_t  pc_o
);

  logic v_q, v_d;
  pc_t  pc_q, pc_d;

  always_comb begin
    v_d  = v_q;
    pc_d = pc_q;
    if (adv_i) begin
      if (hold_i) begin
        v_d = v_q & ~kill_i;
      end else begin
        v_d  = v_i & ~kill_i;
        pc_d = pc_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q  <= 1'b0;
      pc_q <= '0;
    end else begin
      v_q  <= v_d;
      pc_q <= pc_d;
    end
  end

  assign v_o  = v_q;
  assign pc_o = pc_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencing: stage valids, per-stage PCs, fetch PC and held redirects.
// Optional stall/flush counters when PIPE_PERF_CNT_EN is defined.
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            stop_IF,
  input  logic            stop_ID,
  input  logic            set_invalid_IF,
  input  logic            set_invalid_ID,
  input  logic            set_invalid_EX,
  input  logic            set_invalid_MEM,
  input  logic            set_invalid_WB,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            go_to_next,
  output logic            IF_invalid,
  output logic            ID_invalid,
  output logic            EX_invalid,
  output logic            MEM_invalid,
  output logic            WB_invalid,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] ID_PC,
  output logic [XLEN-1:0] EX_PC,
  output logic [XLEN-1:0] MEM_PC,
  output logic [XLEN-1:0] WB_PC,
  output logic            retire
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
`endif
);

  logic go;
  logic flush;

  logic if_v_q, if_v_d;
  pc_t  if_pc_q, if_pc_d;
  logic pend_q, pend_d;
  pc_t  pend_pc_q, pend_pc_d;

  logic id_v, ex_v, mem_v, wb_v;
  pc_t  id_pc, ex_pc, mem_pc, wb_pc;
  logic id_kill, ex_kill, mem_kill, wb_kill;

  logic [NSTAGE-1:0] vld;

  assign go    = imem_ready & dmem_ready;
  // A held redirect squashes the younger stages when it is applied.
  assign flush = pend_q;

  always_comb begin
    if_v_d  = if_v_q;
    if_pc_d = if_pc_q;
    if (go) begin
      if_v_d = 1'b1;
      if (redirect) begin
        if_pc_d = redirect_pc;
      end else if (pend_q) begin
        if_pc_d = pend_pc_q;
      end else if (!stop_IF) begin
        if_pc_d = pc_inc(if_pc_q);
      end
    end
  end

  always_comb begin
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (go) begin
      pend_d = 1'b0;
    end else if (redirect) begin
      pend_d    = 1'b1;
      pend_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_v_q    <= 1'b1;
      if_pc_q   <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      if_v_q    <= if_v_d;
      if_pc_q   <= if_pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // A held ID slot is killed by its own request; a loading one by IF's.
  assign id_kill  = flush | (stop_ID ? set_invalid_ID : set_invalid_IF);
  assign ex_kill  = flush | set_invalid_ID | stop_ID;
  assign mem_kill = flush | set_invalid_EX;
  assign wb_kill  = set_invalid_MEM;

  pipe_stage_reg u_id (
    .clk_i  (clk),
    .rst_i  (reset),
    .adv_i  (go),
    .hold_i (stop_ID),
    .kill_i (id_kill),
    .v_i    (if_v_q),
    .pc_i   (if_pc_q),
    .v_o    (id_v),
    .pc_o   (id_pc)
  );

  pipe_stage_reg u_ex (
    .clk_i  (clk),
    .rst_i  (reset),
    .adv_i  (go),
    .hold_i (1'b0),
    .kill_i (ex_kill),
    .v_i    (id_v),
    .pc_i   (id_pc),
    .v_o    (ex_v),
    .pc_o   (ex_pc)
  );

  pipe_stage_reg u_mem (
    .clk_i  (clk),
    .rst_i  (reset),
    .adv_i  (go),
    .hold_i (1'b0),
    .kill_i (mem_kill),
    .v_i    (ex_v),
    .pc_i   (ex_pc),
    .v_o    (mem_v),
    .pc_o   (mem_pc)
  );

  pipe_stage_reg u_wb (
    .clk_i  (clk),
    .rst_i  (reset),
    .adv_i  (go),
    .hold_i (1'b0),
    .kill_i (wb_kill),
    .v_i    (mem_v),
    .pc_i   (mem_pc),
    .v_o    (wb_v),
    .pc_o   (wb_pc)
  );

  assign vld[ST_IF]  = if_v_q;
  assign vld[ST_ID]  = id_v;
  assign vld[ST_EX]  = ex_v;
  assign vld[ST_MEM] = mem_v;
  assign vld[ST_WB]  = wb_v;

  assign go_to_next  = go;
  assign IF_invalid  = ~vld[ST_IF];
  assign ID_invalid  = ~vld[ST_ID];
  assign EX_invalid  = ~vld[ST_EX];
  assign MEM_invalid = ~vld[ST_MEM];
  assign WB_invalid  = ~vld[ST_WB];
  assign IF_PC       = if_pc_q;
  assign ID_PC       = id_pc;
  assign EX_PC       = ex_pc;
  assign MEM_PC      = mem_pc;
  assign WB_PC       = wb_pc;
  assign retire      = vld[ST_WB] & ~set_invalid_WB;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flcnt_q, flcnt_d;

  always_comb begin
    stall_d = stall_q;
    flcnt_d = flcnt_q;
    if (!go || stop_ID) begin
      stall_d = stall_q + 32'd1;
    end
    if (go && (redirect || pend_q)) begin
      flcnt_d = flcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flcnt_q <= '0;
    end else begin
      stall_q <= stall_d;
      flcnt_q <= flcnt_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flcnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed scenarios plus random traffic
// against an array-based pipeline model.
module tb_pipe_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready, dmem_ready;
  logic        stop_IF, stop_ID;
  logic        set_invalid_IF, set_invalid_ID, set_invalid_EX;
  logic        set_invalid_MEM, set_invalid_WB;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        go_to_next, retire;
  logic        IF_invalid, ID_invalid, EX_invalid, MEM_invalid, WB_invalid;
  logic [31:0] IF_PC, ID_PC, EX_PC, MEM_PC, WB_PC;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipe_stage_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .imem_ready      (imem_ready),
    .dmem_ready      (dmem_ready),
    .stop_IF         (stop_IF),
    .stop_ID         (stop_ID),
    .set_invalid_IF  (set_invalid_IF),
    .set_invalid_ID  (set_invalid_ID),
    .set_invalid_EX  (set_invalid_EX),
    .set_invalid_MEM (set_invalid_MEM),
    .set_invalid_WB  (set_invalid_WB),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .go_to_next      (go_to_next),
    .IF_invalid      (IF_invalid),
    .ID_invalid      (ID_invalid),
    .EX_invalid      (EX_invalid),
    .MEM_invalid     (MEM_invalid),
    .WB_invalid      (WB_invalid),
    .IF_PC           (IF_PC),
    .ID_PC           (ID_PC),
    .EX_PC           (EX_PC),
    .MEM_PC          (MEM_PC),
    .WB_PC           (WB_PC),
    .retire          (retire)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: stage 0 is IF, 4 is WB.
  bit          m_v[5];
  logic [31:0] m_pc[5];
  bit          m_pend;
  logic [31:0] m_ppc;
  logic [31:0] m_stall, m_flush;

  logic [4:0]  d_inv;
  logic [31:0] d_pc[5];
  string       names[5] = '{"IF", "ID", "EX", "MEM", "WB"};

  assign d_inv = {WB_invalid, MEM_invalid, EX_invalid, ID_invalid, IF_invalid};
  assign d_pc[0] = IF_PC;
  assign d_pc[1] = ID_PC;
  assign d_pc[2] = EX_PC;
  assign d_pc[3] = MEM_PC;
  assign d_pc[4] = WB_PC;

  task automatic m_reset();
    for (int i = 0; i < 5; i++) begin
      m_v[i]  = (i == 0);
      m_pc[i] = 32'h0;
    end
    m_pend  = 0;
    m_ppc   = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic m_step();
    bit          go, fl;
    bit          ov[5];
    logic [31:0] op[5];
    bit          si[5];
    go = imem_ready && dmem_ready;
    si = '{set_invalid_IF, set_invalid_ID, set_invalid_EX,
           set_invalid_MEM, set_invalid_WB};
    if (!go || stop_ID) m_stall = m_stall + 1;
    if (!go) begin
      if (redirect) begin
        m_pend = 1;
        m_ppc  = redirect_pc;
      end
      return;
    end
    if (redirect || m_pend) m_flush = m_flush + 1;
    fl = m_pend;
    ov = m_v;
    op = m_pc;
    m_v[4]  = ov[3] && !si[3];
    m_pc[4] = op[3];
    m_v[3]  = ov[2] && !si[2] && !fl;
    m_pc[3] = op[2];
    m_v[2]  = ov[1] && !si[1] && !stop_ID && !fl;
    m_pc[2] = op[1];
    if (stop_ID) begin
      m_v[1] = ov[1] && !si[1] && !fl;
    end else begin
      m_v[1]  = ov[0] && !si[0] && !fl;
      m_pc[1] = op[0];
    end
    if (redirect)     m_pc[0] = redirect_pc;
    else if (m_pend)  m_pc[0] = m_ppc;
    else if (!stop_IF) m_pc[0] = op[0] + 32'd4;
    m_v[0] = 1;
    m_pend = 0;
  endtask

  task automatic compare();
    check("go_to_next", {31'b0, go_to_next},
          {31'b0, imem_ready & dmem_ready});
    for (int i = 0; i < 5; i++) begin
      check({names[i], "_invalid"}, {31'b0, d_inv[i]}, {31'b0, !m_v[i]});
      check({names[i], "_PC"}, d_pc[i], m_pc[i]);
    end
    check("retire", {31'b0, retire}, {31'b0, m_v[4] && !set_invalid_WB});
`ifdef PIPE_PERF_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("flush_count", flush_count, m_flush);
`endif
  endtask

  task automatic clr_ctl();
    stop_IF = 0; stop_ID = 0;
    set_invalid_IF = 0; set_invalid_ID = 0; set_invalid_EX = 0;
    set_invalid_MEM = 0; set_invalid_WB = 0;
    redirect = 0; redirect_pc = 0;
  endtask

  // Inputs are set at the falling edge; outputs checked 1 step later.
  task automatic tick();
    #1 compare();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    m_reset();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1;
    imem_ready = 0; dmem_ready = 0;
    clr_ctl();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    imem_ready = 1; dmem_ready = 1;

    #1;
    check("rst_IF_invalid", {31'b0, IF_invalid}, 32'd0);
    check("rst_ID_invalid", {31'b0, ID_invalid}, 32'd1);
    check("rst_WB_invalid", {31'b0, WB_invalid}, 32'd1);
    check("rst_IF_PC", IF_PC, 32'h0);
    check("rst_retire", {31'b0, retire}, 32'd0);

    // Free run: retire first on the fourth advance.
    repeat (3) tick();
    check("retire_3rd", {31'b0, retire}, 32'd0);
    tick();
    check("retire_4th", {31'b0, retire}, 32'd1);
    check("wb_pc_4th", WB_PC, 32'h0);
    check("if_pc_4th", IF_PC, 32'h10);

    // Load-use stall with ID_PC = 0x10.
    tick();
    check("lu_id_pc", ID_PC, 32'h10);
    stop_IF = 1; stop_ID = 1;
    tick();
    clr_ctl();
    check("lu_if_hold", IF_PC, 32'h14);
    check("lu_id_hold", ID_PC, 32'h10);
    check("lu_ex_bubble", {31'b0, EX_invalid}, 32'd1);
    tick();
    check("lu_resume_if", IF_PC, 32'h18);
    check("lu_resume_id", ID_PC, 32'h14);

    // Taken branch.
    redirect = 1; redirect_pc = 32'h200;
    set_invalid_IF = 1; set_invalid_ID = 1; set_invalid_EX = 1;
    tick();
    clr_ctl();
    check("br_if_pc", IF_PC, 32'h200);
    check("br_id_inv", {31'b0, ID_invalid}, 32'd1);
    check("br_ex_inv", {31'b0, EX_invalid}, 32'd1);
    tick();
    check("br_next_if", IF_PC, 32'h204);

    // Redirect while data memory busy.
    dmem_ready = 0;
    redirect = 1; redirect_pc = 32'h80;
    tick();
    clr_ctl();
    tick();
    tick();
    check("busy_if_frozen", IF_PC, 32'h204);
    check("busy_id_frozen", ID_PC, 32'h200);
    dmem_ready = 1;
    tick();
    check("pend_if_pc", IF_PC, 32'h80);
    check("pend_id_kill", {31'b0, ID_invalid}, 32'd1);
    check("pend_ex_kill", {31'b0, EX_invalid}, 32'd1);
    check("pend_mem_kill", {31'b0, MEM_invalid}, 32'd1);
    tick();
    check("pend_cleared", IF_PC, 32'h84);

    // Wrap, then asynchronous reset between edges.
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    clr_ctl();
    check("wrap_pre", IF_PC, 32'hFFFF_FFFC);
    tick();
    check("wrap_post", IF_PC, 32'h0);
    check("wrap_id", ID_PC, 32'hFFFF_FFFC);
    #1 reset = 1;
    #1 m_reset();
    check("arst_if_pc", IF_PC, 32'h0);
    check("arst_id_pc", ID_PC, 32'h0);
    check("arst_id_inv", {31'b0, ID_invalid}, 32'd1);
    check("arst_wb_inv", {31'b0, WB_invalid}, 32'd1);
    @(negedge clk);
    reset = 0;
    tick();
    check("arst_first_if", IF_PC, 32'h4);
    check("arst_first_id", ID_PC, 32'h0);
    check("arst_first_idv", {31'b0, ID_invalid}, 32'd0);

    // Stall / flush counting.
    do_reset();
    imem_ready = 0;
    repeat (5) tick();
    imem_ready = 1;
    redirect = 1; redirect_pc = 32'h40;
    repeat (2) tick();
    clr_ctl();
    tick();
`ifdef PIPE_PERF_CNT_EN
    check("cnt_stall", stall_cycles, 32'd5);
    check("cnt_flush", flush_count, 32'd2);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      imem_ready      = ($urandom_range(0, 9) < 8);
      dmem_ready      = ($urandom_range(0, 9) < 8);
      stop_ID         = ($urandom_range(0, 9) < 2);
      stop_IF         = stop_ID | ($urandom_range(0, 19) == 0);
      set_invalid_IF  = ($urandom_range(0, 9) == 0);
      set_invalid_ID  = ($urandom_range(0, 9) == 0);
      set_invalid_EX  = ($urandom_range(0, 9) == 0);
      set_invalid_MEM = ($urandom_range(0, 9) == 0);
      set_invalid_WB  = ($urandom_range(0, 9) == 0);
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_pc     = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    clr_ctl();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
